// File: rtl/decode_pkg.sv
// Shared opcodes and instruction field-offset helpers for the decode/issue stage.
package decode_pkg;

   localparam int unsigned OP_ALU = 1;
   localparam int unsigned OP_LW  = 2;
   localparam int unsigned OP_SW  = 3;
   localparam int unsigned OP_BR  = 4;

   // MSB index of register field idx (0 = F0), counting down from just below the opcode.
   function automatic int unsigned field_msb(input int unsigned instr_w,
                                             input int unsigned op_w,
                                             input int unsigned reg_w,
                                             input int unsigned idx);
      return instr_w - op_w - 1 - idx * reg_w;
   endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch-side, issue-side and writeback signals of the decode/issue stage.
interface decode_issue_stage_if #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned OP_W    = 4,
   parameter int unsigned REG_W   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [OP_W-1:0]    out_op;
   logic [REG_W-1:0]   out_rs1;
   logic [REG_W-1:0]   out_rs2;
   logic [REG_W-1:0]   out_rd;
   logic [INSTR_W-1:0] out_instr;
   logic               out_hazard;
   logic               wb_valid;
   logic [REG_W-1:0]   wb_reg;

   // Environment side: feeds instructions, accepts issues, reports writebacks.
   modport master (
      output in_valid, in_instr, flush, out_ready, wb_valid, wb_reg,
      input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_instr, out_hazard
   );

   // Stage side.
   modport slave (
      input  in_valid, in_instr, flush, out_ready, wb_valid, wb_reg,
      output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_instr, out_hazard
   );
endinterface

// File: rtl/decode_scoreboard.sv
// Per-register outstanding-write scoreboard; register 0 is never busy.
module decode_scoreboard #(
   parameter int unsigned REG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_reg,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_reg,
   input  logic [REG_W-1:0] rd_a,
   input  logic [REG_W-1:0] rd_b,
   output logic             busy_hit
);
   localparam int unsigned NUM_REGS = 2 ** REG_W;

   logic [NUM_REGS-1:0] busy_q, busy_d;

   // Next busy vector: clear first so a same-register set overrides it.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_reg] = 1'b0;
      if (set_en) busy_d[set_reg] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Busy vector storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_hit = busy_q[rd_a] | busy_q[rd_b];
endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes register fields into a one-entry valid/ready slot and
// holds issue while a source register has an outstanding write.
// Optional macro DECODE_STALL_COUNT_EN adds a saturating stall_cycles counter.
module decode_issue_stage
   import decode_pkg::*;
#(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned OP_W    = 4,
   parameter int unsigned REG_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   decode_issue_stage_if.slave  bus
`ifdef DECODE_STALL_COUNT_EN
   ,
   output logic [31:0]          stall_cycles
`endif
);
   localparam int unsigned F0 = field_msb(INSTR_W, OP_W, REG_W, 0);
   localparam int unsigned F1 = field_msb(INSTR_W, OP_W, REG_W, 1);
   localparam int unsigned F2 = field_msb(INSTR_W, OP_W, REG_W, 2);

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
   } dec_t;

   function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
      dec_t             d;
      logic [REG_W-1:0] f0, f1, f2;
      d    = '0;
      d.op = instr[INSTR_W-1 -: OP_W];
      f0   = instr[F0 -: REG_W];
      f1   = instr[F1 -: REG_W];
      f2   = instr[F2 -: REG_W];
      case (d.op)
         OP_W'(OP_ALU):               begin d.rs1 = f0; d.rs2 = f1; d.rd = f2; end
         OP_W'(OP_LW):                begin d.rs1 = f0; d.rd = f1; end
         OP_W'(OP_SW), OP_W'(OP_BR):  begin d.rs1 = f0; d.rs2 = f1; end
         default: ;
      endcase
      return d;
   endfunction

   logic               held_valid_q;
   dec_t               dec_q;
   logic [INSTR_W-1:0] instr_q;
   dec_t               dec_in;
   logic               busy_hit, hazard, accept, issue;

   assign dec_in         = decode(bus.in_instr);
   assign hazard         = held_valid_q & busy_hit;
   assign bus.out_hazard = hazard;
   assign bus.out_valid  = held_valid_q & ~hazard;
   assign issue          = bus.out_valid & bus.out_ready;
   assign bus.in_ready   = ~held_valid_q | issue;
   assign accept         = bus.in_valid & bus.in_ready;

   assign bus.out_op    = dec_q.op;
   assign bus.out_rs1   = dec_q.rs1;
   assign bus.out_rs2   = dec_q.rs2;
   assign bus.out_rd    = dec_q.rd;
   assign bus.out_instr = instr_q;

   // Slot: flush drops both the held entry and any same-cycle accept; fields load only on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_valid_q <= 1'b0;
         dec_q        <= '0;
         instr_q      <= '0;
      end else if (bus.flush) begin
         held_valid_q <= 1'b0;
      end else if (accept) begin
         held_valid_q <= 1'b1;
         dec_q        <= dec_in;
         instr_q      <= bus.in_instr;
      end else if (issue) begin
         held_valid_q <= 1'b0;
      end
   end

   // An issue in a flush cycle still marks its destination busy.
   decode_scoreboard #(
      .REG_W (REG_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (issue & (dec_q.rd != '0)),
      .set_reg  (dec_q.rd),
      .clr_en   (bus.wb_valid),
      .clr_reg  (bus.wb_reg),
      .rd_a     (dec_q.rs1),
      .rd_b     (dec_q.rs2),
      .busy_hit (busy_hit)
   );

`ifdef DECODE_STALL_COUNT_EN
   logic [31:0] stall_q;

   // Saturating count of cycles spent blocked by the scoreboard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         stall_q <= '0;
      else if (hazard && stall_q != '1) stall_q <= stall_q + 32'd1;
   end

   assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage.
module tb_decode_issue_stage;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   decode_issue_stage_if #(.INSTR_W(32), .OP_W(4), .REG_W(4)) bus ();

`ifdef DECODE_STALL_COUNT_EN
   logic [31:0] stall_cycles;
`endif

   decode_issue_stage #(
      .INSTR_W (32),
      .OP_W    (4),
      .REG_W   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DECODE_STALL_COUNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.flush = 1'b0;
      bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_reg = '0;
      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_hazard", bus.out_hazard, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_op", bus.out_op, 0);
      chk("rst_rs1", bus.out_rs1, 0);
      chk("rst_rs2", bus.out_rs2, 0);
      chk("rst_rd", bus.out_rd, 0);
      chk("rst_instr", bus.out_instr, 0);
      rst = 1'b0;

      // ALU accept, 1-cycle latency
      cyc();
      bus.in_valid = 1'b1; bus.in_instr = 32'h1234_0000;
      #1 chk("alu_in_ready", bus.in_ready, 1);
      cyc();
      bus.in_valid = 1'b0;
      #1;
      chk("alu_valid", bus.out_valid, 1);
      chk("alu_op", bus.out_op, 1);
      chk("alu_rs1", bus.out_rs1, 2);
      chk("alu_rs2", bus.out_rs2, 3);
      chk("alu_rd", bus.out_rd, 4);
      chk("alu_hazard", bus.out_hazard, 0);
      chk("alu_instr", bus.out_instr, 32'h1234_0000);

      // issue ALU (busy[4]) while accepting SW that reads r4
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h3470_0000;
      #1 chk("b2b_in_ready", bus.in_ready, 1);
      cyc();
      bus.in_valid = 1'b0;
      #1;
      chk("sw_op", bus.out_op, 3);
      chk("sw_rs1", bus.out_rs1, 4);
      chk("sw_rs2", bus.out_rs2, 7);
      chk("sw_rd", bus.out_rd, 0);
      chk("sw_hazard", bus.out_hazard, 1);
      chk("sw_valid", bus.out_valid, 0);
      chk("sw_in_ready", bus.in_ready, 0);
      cyc();
      chk("sw_hazard_hold", bus.out_hazard, 1);
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd4;
      #1 chk("wb_no_bypass", bus.out_valid, 0);
      cyc();
      bus.wb_valid = 1'b0;
      #1;
      chk("sw_valid_after_wb", bus.out_valid, 1);
      chk("sw_hazard_after_wb", bus.out_hazard, 0);

      // SW issues, LW accepted
      bus.in_valid = 1'b1; bus.in_instr = 32'h2560_0000;
      #1 chk("lw_in_ready", bus.in_ready, 1);
      cyc();
      #1;
      chk("lw_op", bus.out_op, 2);
      chk("lw_rs1", bus.out_rs1, 5);
      chk("lw_rs2", bus.out_rs2, 0);
      chk("lw_rd", bus.out_rd, 6);
      chk("lw_valid", bus.out_valid, 1);

      // LW issues with same-cycle wb of r6; SW reading r6 follows
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd6; bus.in_instr = 32'h3600_0000;
      cyc();
      bus.wb_valid = 1'b0; bus.in_valid = 1'b0;
      #1;
      chk("setwins_rs1", bus.out_rs1, 6);
      chk("setwins_hazard", bus.out_hazard, 1);
      chk("setwins_valid", bus.out_valid, 0);
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd0;
      cyc();
      bus.wb_valid = 1'b0;
      #1 chk("wb_r0_no_effect", bus.out_hazard, 1);
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd6;
      cyc();
      bus.wb_valid = 1'b0;
      #1 chk("r6_cleared", bus.out_valid, 1);

      // ALU writing r2, then invalid opcodes touching r2 fields
      bus.in_valid = 1'b1; bus.in_instr = 32'h1112_0000;
      cyc();
      chk("alu2_rd", bus.out_rd, 2);
      bus.in_instr = 32'hF222_0000;
      cyc();
      #1;
      chk("opF_op", bus.out_op, 4'hF);
      chk("opF_rs1", bus.out_rs1, 0);
      chk("opF_rs2", bus.out_rs2, 0);
      chk("opF_rd", bus.out_rd, 0);
      chk("opF_hazard", bus.out_hazard, 0);
      chk("opF_valid", bus.out_valid, 1);
      bus.in_instr = 32'h0222_0000;
      cyc();
      #1;
      chk("op0_rs1", bus.out_rs1, 0);
      chk("op0_rd", bus.out_rd, 0);
      chk("op0_valid", bus.out_valid, 1);
      bus.in_instr = 32'h3200_0000;
      cyc();
      bus.in_valid = 1'b0;
      #1;
      chk("busy2_kept_hazard", bus.out_hazard, 1);

      // flush a stalled instruction
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      #1;
      chk("flush_valid", bus.out_valid, 0);
      chk("flush_hazard", bus.out_hazard, 0);
      chk("flush_in_ready", bus.in_ready, 1);
      chk("flush_fields_held", bus.out_rs1, 2);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h1567_0000;
      cyc();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      #1;
      chk("flush_drop_valid", bus.out_valid, 0);
      chk("flush_drop_instr", bus.out_instr, 32'h3200_0000);
      bus.in_valid = 1'b1; bus.in_instr = 32'h3200_0000;
      cyc();
      bus.in_valid = 1'b0;
      #1 chk("flush_busy_kept", bus.out_hazard, 1);

      // asynchronous reset mid-stall
      rst = 1'b1;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_hazard", bus.out_hazard, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      chk("arst_op", bus.out_op, 0);
      chk("arst_rs1", bus.out_rs1, 0);
      chk("arst_instr", bus.out_instr, 0);
`ifdef DECODE_STALL_COUNT_EN
      chk("arst_stall", stall_cycles, 0);
`endif
      rst = 1'b0;
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h3200_0000;
      cyc();
      bus.in_valid = 1'b0;
      #1;
      chk("arst_busy_cleared", bus.out_hazard, 0);
      chk("arst_reissue_valid", bus.out_valid, 1);

      // five-cycle hazard
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h1112_0000;
      cyc();
      bus.in_instr = 32'h3200_0000;
      cyc();
      bus.in_valid = 1'b0;
      repeat (5) cyc();
      chk("stall_hazard", bus.out_hazard, 1);
      chk("stall_in_ready", bus.in_ready, 0);
`ifdef DECODE_STALL_COUNT_EN
      chk("stall_cycles5", stall_cycles, 5);
`endif
      bus.wb_valid = 1'b1; bus.wb_reg = 4'd2;
      cyc();
      bus.wb_valid = 1'b0;
      #1 chk("stall_release", bus.out_valid, 1);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
